// File: rtl/mipi_cmd_seq.sv
// Command-table sequencer: walks a synchronous ROM of PKT / DELAY / END entries
// and hands packets one at a time to a downstream MIPI packet assembler.
module mipi_cmd_seq #(
    parameter int          TBL_AW      = 8,
    parameter logic [23:0] TIMEOUT_CYC = 24'd1000000,
    parameter logic [15:0] DLY_UNIT    = 16'd1000
) (
    input  logic              clkin,
    input  logic              rstn,
    input  logic              seq_go,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [31:0]       tbl_data,
    output logic              pkt_start,
    output logic [5:0]        pkt_dt,
    output logic [15:0]       pkt_wc,
    output logic              hs_cfg,
    input  logic              packet_finish,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_err
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, START, WAIT, DELAY, DONE, ERR} state_t;
    typedef enum logic [1:0] {OP_END = 2'b00, OP_PKT = 2'b01, OP_DLY = 2'b10, OP_BAD = 2'b11} op_t;

    state_t            state, state_nxt;
    logic [TBL_AW-1:0] addr_nxt;
    logic [5:0]        dt_nxt;
    logic [15:0]       wc_nxt;
    logic              hs_nxt, busy_nxt, err_nxt;
    logic              fin_q, fin_edge;
    logic [23:0]       wait_cnt, wait_nxt;
    logic [31:0]       dly_cnt, dly_nxt;
    logic              adv, fail;
    op_t               op;
    logic              unused_bits;

    assign op          = op_t'(tbl_data[31:30]);
    assign fin_edge    = packet_finish & ~fin_q;
    assign unused_bits = ^tbl_data[28:22];

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            tbl_addr <= '0;
            pkt_dt   <= '0;
            pkt_wc   <= '0;
            hs_cfg   <= 1'b0;
            seq_busy <= 1'b0;
            seq_err  <= 1'b0;
            fin_q    <= 1'b0;
            wait_cnt <= '0;
            dly_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            tbl_addr <= addr_nxt;
            pkt_dt   <= dt_nxt;
            pkt_wc   <= wc_nxt;
            hs_cfg   <= hs_nxt;
            seq_busy <= busy_nxt;
            seq_err  <= err_nxt;
            fin_q    <= packet_finish;
            wait_cnt <= wait_nxt;
            dly_cnt  <= dly_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = tbl_addr;
        dt_nxt    = pkt_dt;
        wc_nxt    = pkt_wc;
        hs_nxt    = hs_cfg;
        busy_nxt  = seq_busy;
        err_nxt   = seq_err;
        wait_nxt  = wait_cnt;
        dly_nxt   = dly_cnt;
        pkt_start = 1'b0;
        seq_done  = 1'b0;
        adv       = 1'b0;
        fail      = 1'b0;

        case (state)
            IDLE: begin
                if (seq_go) begin
                    addr_nxt  = '0;
                    err_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: state_nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_END: begin
                        hs_nxt    = 1'b0;
                        busy_nxt  = 1'b0;
                        state_nxt = DONE;
                    end
                    OP_PKT: begin
                        hs_nxt    = tbl_data[29];
                        dt_nxt    = tbl_data[21:16];
                        wc_nxt    = tbl_data[15:0];
                        state_nxt = START;
                    end
                    OP_DLY: begin
                        dly_nxt   = {16'b0, tbl_data[15:0]} * {16'b0, DLY_UNIT};
                        state_nxt = DELAY;
                    end
                    default: fail = 1'b1;
                endcase
            end
            START: begin
                pkt_start = 1'b1;
                wait_nxt  = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // a finish edge in the expiry cycle still counts as success
                if (fin_edge)
                    adv = 1'b1;
                else if (wait_cnt + 24'd1 >= TIMEOUT_CYC)
                    fail = 1'b1;
                else
                    wait_nxt = wait_cnt + 24'd1;
            end
            DELAY: begin
                if (dly_cnt <= 32'd1)
                    adv = 1'b1;
                else
                    dly_nxt = dly_cnt - 32'd1;
            end
            DONE: begin
                seq_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (adv) begin
            if (&tbl_addr) begin
                fail = 1'b1;
            end else begin
                addr_nxt  = tbl_addr + 1'b1;
                state_nxt = FETCH;
            end
        end

        if (fail) begin
            err_nxt   = 1'b1;
            hs_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            state_nxt = ERR;
        end
    end
endmodule

// File: doc/mipi_cmd_seq.md
MIPI_CMD_SEQ -- requirements
Module: mipi_cmd_seq

Interface
REQ-001 Parameter TBL_AW, default 8, command-table address width.
REQ-002 Parameter TIMEOUT_CYC, default 24'd1000000, max clkin cycles spent waiting for one packet to finish.
REQ-003 Parameter DLY_UNIT, default 16'd1000, clkin cycles per DELAY unit.
REQ-004 clkin  in  1  system clock; all logic on its rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 seq_go  in  1  one-cycle pulse; starts sequence at table address 0.
REQ-007 tbl_addr  out  TBL_AW  command-table read address.
REQ-008 tbl_data  in  32  table entry; valid exactly 1 cycle after tbl_addr changes (synchronous ROM).
REQ-009 pkt_start  out  1  one-cycle pulse requesting one packet from the downstream packet assembler.
REQ-010 pkt_dt  out  6  MIPI data type of the current packet.
REQ-011 pkt_wc  out  16  word count / short-packet parameter of the current packet.
REQ-012 hs_cfg  out  1  1 = send current packet in HS, 0 = LP.
REQ-013 packet_finish  in  1  level from packet assembler; cleared by it after pkt_start, set when TX activity ends.
REQ-014 seq_busy  out  1  high from seq_go acceptance until DONE/ERR.
REQ-015 seq_done  out  1  one-cycle pulse on END entry reached.
REQ-016 seq_err  out  1  sticky error flag; cleared on next accepted seq_go.

Function
REQ-017 Entry format: [31:30] op (00 END, 01 PKT, 10 DELAY, 11 illegal); PKT: [29] hs, [21:16] dt, [15:0] wc; DELAY: [15:0] units.
REQ-018 FSM states: IDLE, FETCH, DECODE, START, WAIT, DELAY, DONE, ERR.
REQ-019 IDLE: seq_go -> tbl_addr=0, seq_err=0, seq_busy=1, go FETCH; seq_go ignored in any other state.
REQ-020 FETCH: one cycle, then DECODE (tbl_data sampled in DECODE).
REQ-021 DECODE PKT: register pkt_dt, pkt_wc, hs_cfg from entry; go START.
REQ-022 START: pkt_start=1 for exactly one cycle; wait counter cleared; go WAIT.
REQ-023 WAIT: rising edge of packet_finish (registered previous value 0, current 1) -> advance; a level already high at entry SHALL NOT complete the packet.
REQ-024 DECODE DELAY: load count = units*DLY_UNIT (32-bit product); units=0 advances after one cycle in DELAY; otherwise stay in DELAY until count expires.
REQ-025 Advance: tbl_addr+1, go FETCH; if tbl_addr is all-ones -> ERR (no wrap).
REQ-026 DECODE END -> DONE: seq_done pulse one cycle, hs_cfg=0, seq_busy=0, go IDLE.
REQ-027 DECODE op 11 -> ERR.
REQ-028 WAIT counter reaching TIMEOUT_CYC without finish edge -> ERR.
REQ-029 ERR: seq_err=1, hs_cfg=0, seq_busy=0, go IDLE in the next cycle.
REQ-030 pkt_dt/pkt_wc/hs_cfg SHALL remain stable from START through WAIT exit.
REQ-031 packet_finish edge arriving in the same cycle as timeout expiry: finish wins (advance, no error).

Reset
REQ-032 rstn low, at any time including mid-sequence: state IDLE, tbl_addr=0, pkt_start=0, pkt_dt=0, pkt_wc=0, hs_cfg=0, seq_busy=0, seq_done=0, seq_err=0, all counters 0.
REQ-033 After rstn release no packet is issued until a new seq_go.

Verification
REQ-034 Table {PKT hs=1 dt=0x39 wc=3, END}, finish rises 50 cycles after pkt_start -> one pkt_start, dt=0x39, wc=3, hs_cfg=1, seq_done pulse, seq_busy low, hs_cfg 0.
REQ-035 Table {PKT, DELAY 2, PKT, END}, DLY_UNIT=10 -> second pkt_start no earlier than 20 cycles after first packet's finish edge; exactly two pulses.
REQ-036 packet_finish held high before and never toggled, TIMEOUT_CYC=100 -> seq_err=1 exactly 100 cycles into WAIT, no seq_done; next seq_go clears seq_err.
REQ-037 Entry op=11 at address 1 -> seq_err=1, only one pkt_start issued; table with no END, TBL_AW=2 -> seq_err after address 3.
REQ-038 rstn asserted during WAIT -> all outputs at reset values immediately; seq_go mid-sequence ignored (no restart, addresses continue).
